// File: rtl/key_select_encoder_pkg.sv
// key_select_encoder_pkg: FSM states, select codes and priority encoder shared with the select decoder
package key_select_encoder_pkg;

    localparam int NUM_KEYS = 15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DEB  = 2'd1,
        EMIT = 2'd2,
        REL  = 2'd3
    } state_t;

    localparam logic [3:0] SEL_NONE  = 4'd0;
    localparam logic [3:0] SEL_TRK1  = 4'd1;
    localparam logic [3:0] SEL_TRK2  = 4'd2;
    localparam logic [3:0] SEL_TRK3  = 4'd3;
    localparam logic [3:0] SEL_TRK4  = 4'd4;
    localparam logic [3:0] SEL_TRK5  = 4'd5;
    localparam logic [3:0] SEL_TRK6  = 4'd6;
    localparam logic [3:0] SEL_TRK7  = 4'd7;
    localparam logic [3:0] SEL_TRK8  = 4'd8;
    localparam logic [3:0] SEL_TRK9  = 4'd9;
    localparam logic [3:0] SEL_CONT  = 4'd10;
    localparam logic [3:0] SEL_PAUSE = 4'd11;
    localparam logic [3:0] SEL_VOLUP = 4'd12;
    localparam logic [3:0] SEL_VOLDN = 4'd13;
    localparam logic [3:0] SEL_NEXT  = 4'd14;
    localparam logic [3:0] SEL_PREV  = 4'd15;

    // Scanning from the top down lets the lowest set key overwrite higher ones.
    function automatic logic [3:0] prio_code(input logic [NUM_KEYS-1:0] v);
        logic [3:0] c;
        c = SEL_NONE;
        for (int i = NUM_KEYS - 1; i >= 0; i--)
            if (v[i]) c = 4'(i + 1);
        return c;
    endfunction

endpackage

// File: rtl/key_select_encoder_sync.sv
// key_sync: two-flop synchroniser per bit, resetting to all ones (keys released)
module key_sync #(
    parameter int W = 15
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] s1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= '1;
            q  <= '1;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end

endmodule

// File: rtl/key_select_encoder.sv
// key_select_encoder: synchronises, debounces and priority-encodes front-panel keys into a select code
module key_select_encoder
    import key_select_encoder_pkg::*;
#(
    parameter int DEB_CYCLES  = 1000000,
    parameter int HOLD_CYCLES = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_KEYS-1:0] keys_n,
    output logic [3:0]          select,
    output logic                select_valid,
    output logic                busy
);

    localparam int CW = $clog2(DEB_CYCLES) + 1;
    localparam int HW = $clog2(HOLD_CYCLES) + 1;
    localparam logic [CW-1:0] DEB_LAST  = CW'(DEB_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

    logic [NUM_KEYS-1:0] keys_s;
    logic [NUM_KEYS-1:0] kv;
    logic [NUM_KEYS-1:0] lv;
    logic [CW-1:0]       cnt;
    logic [HW-1:0]       hcnt;
    state_t              state;

    key_sync #(.W(NUM_KEYS)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (keys_n),
        .q     (keys_s)
    );

    assign kv   = ~keys_s;
    assign busy = (state != IDLE);

    // Counters are compared before incrementing, so they never wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            lv           <= '0;
            cnt          <= '0;
            hcnt         <= '0;
            select       <= SEL_NONE;
            select_valid <= 1'b0;
        end else begin
            select_valid <= 1'b0;
            case (state)
                IDLE: if (kv != '0) begin
                    lv    <= kv;
                    cnt   <= '0;
                    state <= DEB;
                end
                DEB: if (kv == '0) begin
                    state <= IDLE;
                end else if (kv != lv) begin
                    lv  <= kv;
                    cnt <= '0;
                end else if (cnt == DEB_LAST) begin
                    state        <= EMIT;
                    select       <= prio_code(lv);
                    select_valid <= 1'b1;
                    hcnt         <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                EMIT: if (hcnt == HOLD_LAST) begin
                    select <= SEL_NONE;
                    cnt    <= '0;
                    state  <= REL;
                end else begin
                    hcnt <= hcnt + 1'b1;
                end
                REL: if (kv != '0) begin
                    cnt <= '0;
                end else if (cnt == DEB_LAST) begin
                    state <= IDLE;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_key_select_encoder.sv
// tb_key_select_encoder: directed test plan plus random key traffic against a timestamp-based reference
module tb_key_select_encoder;

    localparam int DEB  = 8;
    localparam int HOLD = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [14:0] keys_n = '1;
    logic [3:0]  select;
    logic        select_valid;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int bursts = 0;
    int last_code = 0;

    key_select_encoder #(.DEB_CYCLES(DEB), .HOLD_CYCLES(HOLD)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .keys_n       (keys_n),
        .select       (select),
        .select_valid (select_valid),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] ref_code(input logic [14:0] v);
        for (int i = 0; i < 15; i++)
            if (v[i]) return 4'(i + 1);
        return 4'd0;
    endfunction

    // Reference: phase 0 waiting, 1 settling, 2 showing, 3 draining; timing kept as edge timestamps.
    logic [14:0] p1 = '1, p2 = '1, kvm, cand = '0;
    logic [3:0]  m_sel = '0;
    logic        m_val = 1'b0;
    int t = 0, phase = 0, set_t = 0, burst_t = 0, quiet_t = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p1 = '1; p2 = '1; phase = 0; m_sel = '0; m_val = 1'b0; t = 0;
        end else begin
            kvm = ~p2; p2 = p1; p1 = keys_n; t++; m_val = 1'b0;
            if (phase == 0) begin
                if (kvm != 0) begin cand = kvm; set_t = t; phase = 1; end
            end else if (phase == 1) begin
                if (kvm == 0) phase = 0;
                else if (kvm != cand) begin cand = kvm; set_t = t; end
                else if (t - set_t == DEB) begin
                    burst_t = t; phase = 2; m_sel = ref_code(cand); m_val = 1'b1;
                end
            end else if (phase == 2) begin
                if (t - burst_t == HOLD) begin m_sel = '0; phase = 3; quiet_t = t; end
            end else begin
                if (kvm != 0) quiet_t = t;
                else if (t - quiet_t == DEB) phase = 0;
            end
        end
    end

    always @(negedge clk) begin
        chk("select", int'(select), int'(m_sel));
        chk("select_valid", int'(select_valid), int'(m_val));
        chk("busy", int'(busy), int'(phase != 0));
        if (select_valid) begin bursts++; last_code = int'(select); end
    end

    task automatic run(input logic [14:0] k, input int n);
        keys_n = ~k;
        repeat (n) @(negedge clk);
    endtask

    int n, b0;
    logic [14:0] k;

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        run('0, 3);
        chk("reset_select", int'(select), 0);
        chk("reset_busy", int'(busy), 0);

        b0 = bursts;
        keys_n = ~15'(1 << 2);
        n = 0;
        do begin @(posedge clk); n++; @(negedge clk); end while (select == 0 && n < 40);
        chk("s1_latency", n, 11);
        run(15'(1 << 2), 29);
        chk("s1_bursts", bursts - b0, 1);
        chk("s1_code", last_code, 3);
        keys_n = '1;
        n = 0;
        do begin @(posedge clk); n++; @(negedge clk); end while (busy && n < 40);
        chk("s1_busy_fall", n, 10);
        run('0, 5);

        b0 = bursts;
        run(15'(1 << 12), 3);
        run('0, 20);
        chk("s2_bursts", bursts - b0, 0);
        chk("s2_idle", int'(busy), 0);

        b0 = bursts;
        run(15'((1 << 9) | (1 << 4)), 40);
        run('0, 20);
        chk("s3_bursts", bursts - b0, 1);
        chk("s3_code", last_code, 5);

        b0 = bursts;
        run(15'(1 << 14), 6);
        run(15'((1 << 14) | 1), 30);
        run('0, 20);
        chk("s4_bursts", bursts - b0, 1);
        chk("s4_code", last_code, 1);

        b0 = bursts;
        run(15'(1 << 10), 25);
        for (int i = 0; i < 5; i++) run((i % 2 == 1) ? 15'(1 << 10) : 15'(0), 4);
        run('0, 30);
        chk("s5_bursts", bursts - b0, 1);
        chk("s5_code", last_code, 11);
        run(15'(1 << 11), 25);
        run('0, 20);
        chk("s5_next_bursts", bursts - b0, 2);
        chk("s5_next_code", last_code, 12);

        b0 = bursts;
        keys_n = ~15'(1 << 6);
        n = 0;
        do begin @(negedge clk); n++; end while (select == 0 && n < 40);
        chk("s6_emit", int'(select), 7);
        #2 rst_n = 1'b0;
        #1;
        chk("s6_rst_select", int'(select), 0);
        chk("s6_rst_valid", int'(select_valid), 0);
        chk("s6_rst_busy", int'(busy), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run(15'(1 << 6), 30);
        run('0, 20);
        chk("s6_bursts", bursts - b0, 2);
        chk("s6_code", last_code, 7);

        for (int it = 0; it < 60; it++) begin
            case ($urandom_range(0, 3))
                0: k = '0;
                1: k = 15'(1 << $urandom_range(0, 14));
                2: k = 15'((1 << $urandom_range(0, 14)) | (1 << $urandom_range(0, 14)));
                default: k = 15'($urandom);
            endcase
            run(k, $urandom_range(1, 25));
            if ($urandom_range(0, 19) == 0) begin
                #2 rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
        end
        run('0, 30);
        chk("final_idle", int'(busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/key_select_encoder.md
Name: key_select_encoder

Overview:
- Front-panel key encoder. Takes 15 raw active-low push-buttons: 9 track keys and 6 function keys (continue, pause, vol+, vol-, next, previous).
- Synchronises and debounces the keys, then priority-encodes one accepted press into the 4-bit select code used by the playback control path.
- select = 0 means "no command"; codes 1..9 are tracks 1..9, codes 10..15 are functions f0..f5.
- Sits between the board buttons and the select decoder. Each press produces exactly one code burst.

Parameters:
- DEB_CYCLES, 1000000, clocks a key vector must be stable to accept a press or a release (20 ms at 50 MHz).
- HOLD_CYCLES, 4, clocks the code is held on select before returning to 0 (must be >= 1).

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- keys_n  input  15  raw buttons, active-low, asynchronous to clk; bit 0..8 = track 1..9, bit 9..14 = f0..f5
- select  output  4  encoded command code; 0 when idle
- select_valid  output  1  one-clock strobe on the first cycle a nonzero code appears on select
- busy  output  1  high in every state except IDLE

Behaviour:
- Reset is asynchronous and active-low on clk. Reset values: select=0, select_valid=0, busy=0, FSM=IDLE, counters=0, synchroniser flops=all ones (keys released).
- Synchroniser: two flops per key, then inversion. kv[14:0] = synchronised key vector, active-high.
- IDLE:
  - if kv != 0: latch kv into lv, clear cnt, go to DEB.
  - otherwise stay in IDLE.
- DEB:
  - if kv == 0: go to IDLE (glitch rejected).
  - else if kv != lv: lv <= kv, cnt <= 0 (restart).
  - else if cnt == DEB_CYCLES-1: go to EMIT. select <= code(lv), select_valid <= 1, hcnt <= 0.
  - else cnt++.
- EMIT:
  - select holds the code and select_valid is 0 after the first cycle.
  - When hcnt == HOLD_CYCLES-1: select <= 0, cnt <= 0, go to REL. Otherwise hcnt++.
  - select is therefore nonzero for exactly HOLD_CYCLES clocks.
- REL:
  - if kv != 0: cnt <= 0.
  - else if cnt == DEB_CYCLES-1: go to IDLE.
  - else cnt++.
  - Keys must be released and stable for DEB_CYCLES before the next press is accepted. A key held indefinitely yields one code only.
- code(v) is a priority encode, lowest set index wins: code = index+1. Example: bit 0 gives 1, bit 8 gives 9, bit 9 gives 10, bit 14 gives 15.
  - Multiple keys pressed together: lowest index wins.
  - A change of pressed-key set during DEB restarts debounce on the new set.
- Latency: select becomes nonzero 3+DEB_CYCLES clocks after the first clk edge that samples the new raw level (2 sync + 1 detect + DEB_CYCLES).
- Counters: cnt has width $clog2(DEB_CYCLES)+1 and hcnt has width $clog2(HOLD_CYCLES)+1. Neither counter wraps, because it is compared before incrementing.
- Reset mid-operation: everything returns immediately to the reset values. A key still held after reset release is treated as a new press. It is debounced and emitted once.
- select and select_valid are registered outputs with no combinational path from keys_n.

Decomposition:
- Shared package:
  - FSM state enum (IDLE, DEB, EMIT, REL).
  - Code constants: SEL_NONE=0, SEL_TRK1..SEL_TRK9=1..9, SEL_CONT=10, SEL_PAUSE=11, SEL_VOLUP=12, SEL_VOLDN=13, SEL_NEXT=14, SEL_PREV=15.
  - These constants are reused by the select decoder.
- One sub-module, key_sync: 2-flop synchroniser, parameterised on width, reset value all ones.
- The debounce FSM and priority encoder stay in the top module.

Test Plan (DEB_CYCLES=8, HOLD_CYCLES=4):
- Press key bit 2 (keys_n[2]=0) and hold for 40 clocks. Required: select=3 for exactly 4 clocks starting 11 clocks after the edge that first samples the press. select_valid is high for the first of those clocks only. busy stays high until 8 clocks after release is synchronised. No second code while the key is held.
- 3-clock glitch on keys_n[12]. Required: select stays 0, select_valid stays 0, FSM returns to IDLE.
- keys_n[9] and keys_n[4] pressed simultaneously and held. Required: single burst of select=5.
- Press keys_n[14]. At debounce cycle 5, also press keys_n[0]. Required: debounce restarts. After 8 more stable clocks, select=1 (not 15).
- Release bounce: after the burst for keys_n[10] (select=11), bounce the key every 4 clocks for 20 clocks, then release it cleanly. Required: no new code. busy falls 8 clocks after the last bounce. A following press of keys_n[11] yields select=12.
- Assert rst_n low during EMIT with select=7. Required: select=0, select_valid=0, busy=0 immediately. After reset release with the key still held, one new burst of select=7.
